// File: rtl/riconoscitore_sequenze_param_if.sv
// Symbol bus of the sequence recogniser: the symbol stream, the pattern-load
// controls, and the recogniser's match, prefix and count outputs.
interface riconoscitore_sequenze_param_if #(
  parameter int W  = 2,
  parameter int K  = 3,
  parameter int CW = 8
);
  localparam int SW = $clog2(K);

  logic [W-1:0]   x;
  logic           en;
  logic           load;
  logic [K*W-1:0] seq_in;
  logic           z;
  logic [SW-1:0]  stato;
  logic [CW-1:0]  conteggio;

  modport master (
    output x, en, load, seq_in,
    input  z, stato, conteggio
  );

  modport slave (
    input  x, en, load, seq_in,
    output z, stato, conteggio
  );
endinterface

// File: rtl/riconoscitore_sequenze_param.sv
// Parametrised Mealy recogniser for a programmable K-symbol pattern, with
// KMP-style fallback, optional overlapping matches and a saturating counter.
module riconoscitore_sequenze_param #(
  parameter int             W       = 2,
  parameter int             K       = 3,
  parameter int             OVERLAP = 1,
  parameter int             CW      = 8,
  parameter logic [K*W-1:0] SEQ_RST = 6'b10_01_11
) (
  input logic clock,
  input logic reset_,
  riconoscitore_sequenze_param_if.slave bus
);
  localparam int             SW      = $clog2(K);
  localparam logic [SW-1:0]  LAST    = SW'(K - 1);
  localparam logic [CW-1:0]  CNT_MAX = '1;

  logic [K*W-1:0] pattern;
  logic [SW-1:0]  stato;
  logic [CW-1:0]  conteggio;
  logic [SW-1:0]  stepState;
  logic [SW-1:0]  candidate;
  logic           z;
  logic [W-1:0]   seq [K];
  logic           prefixOk [K][K];

  always_comb begin
    for (int i = 0; i < K; i++) begin
      seq[i] = pattern[i*W +: W];
    end
  end

  // prefixOk[s][j]: with s symbols matched, seq[0..j-2] is also a suffix of
  // that matched prefix, so a fallback to length j is possible if x fits.
  always_comb begin
    for (int s = 0; s < K; s++) begin
      for (int j = 0; j < K; j++) begin
        prefixOk[s][j] = 1'b0;
      end
    end
    for (int s = 0; s < K; s++) begin
      for (int j = 1; j < K; j++) begin
        if (j - 1 <= s) begin
          prefixOk[s][j] = 1'b1;
          for (int m = 0; m < j - 1; m++) begin
            if (seq[m] != seq[s-j+1+m]) begin
              prefixOk[s][j] = 1'b0;
            end
          end
        end
      end
    end
  end

  assign z = bus.en & reset_ & ~bus.load & (stato == LAST) & (bus.x == seq[K-1]);

  // Longest valid candidate below K wins; a full match never parks at K.
  always_comb begin
    candidate = '0;
    for (int j = 1; j < K; j++) begin
      if (prefixOk[stato][j] && (bus.x == seq[j-1])) begin
        candidate = SW'(j);
      end
    end
    stepState = candidate;
    if (z && (OVERLAP == 0)) begin
      stepState = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      pattern   <= SEQ_RST;
      stato     <= '0;
      conteggio <= '0;
    end else if (bus.load) begin
      pattern <= bus.seq_in;
      stato   <= '0;
    end else if (bus.en) begin
      stato <= stepState;
      if (z && (conteggio != CNT_MAX)) begin
        conteggio <= conteggio + 1'b1;
      end
    end
  end

  assign bus.z         = z;
  assign bus.stato     = stato;
  assign bus.conteggio = conteggio;
endmodule
